fetch_pc_ctrl: RTL and testbench

IF0 sequencer for the fetch pipeline. It owns the fetch PC and issues one 16-byte-aligned I-cache block request per handoff. It builds the per-slot valid/jump masks and the `{pc_valid, pc_is_jump, fs_pc}` bus consumed by IF1. It also applies backend redirects, branch-predictor hints, idle halt and misaligned-PC blocking, and drives the IF1 flush.

---
 rtl/fetch_pc_ctrl_pkg.sv | 21 ++
 rtl/fetch_pc_ctrl_mask_gen.sv | 47 ++++
 rtl/fetch_pc_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared definitions for the IF0 fetch sequencer.
//   IF0_TO_IF1_BUS_WD : width of the IF0->IF1 bus {pc_valid[3:0], pc_is_jump[3:0], fs_pc[31:0]}
//   RESET_PC_DEFAULT  : default fetch PC after reset
//   fetch_state_e     : IF0 sequencer states
package fetch_pc_ctrl_pkg;

  localparam int          IF0_TO_IF1_BUS_WD = 40;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_BLOCK = 2'd2
  } fetch_state_e;

  // A fetch PC is usable only if it is word aligned.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_mask_gen.sv
// fetch_mask_gen: combinational per-slot valid/jump mask builder for one
// 16-byte fetch block (four 32-bit slots).
// Ports:
//   pc_slot    in  2  fetch_pc[3:2], first slot fetched in the block
//   bpu_taken  in  1  predictor reports a taken jump in this block
//   bpu_slot   in  2  slot of the predicted-taken instruction
//   pc_valid   out 4  slots that belong to the fetch stream
//   pc_is_jump out 4  one-hot marker of the predicted-taken slot
//   use_pred   out 1  prediction is applied (slot not behind the PC)
module fetch_mask_gen
  import fetch_pc_ctrl_pkg::*;
(
  input  logic [1:0] pc_slot,
  input  logic       bpu_taken,
  input  logic [1:0] bpu_slot,
  output logic [3:0] pc_valid,
  output logic [3:0] pc_is_jump,
  output logic       use_pred
);

  logic       use_pred_s;
  logic [3:0] valid_s;
  logic [3:0] jump_s;

  // Slots run from the PC offset up to the predicted-taken slot (or block end).
  always_comb begin
    use_pred_s = bpu_taken & (bpu_slot >= pc_slot);
    valid_s    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) >= pc_slot) && (!use_pred_s || (2'(i) <= bpu_slot))) begin
        valid_s[i] = 1'b1;
      end else begin
        valid_s[i] = 1'b0;
      end
    end
    if (use_pred_s) begin
      jump_s = 4'b0001 << bpu_slot;
    end else begin
      jump_s = 4'b0000;
    end
  end

  assign use_pred   = use_pred_s;
  assign pc_valid   = valid_s;
  assign pc_is_jump = jump_s;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF0 sequencer. Owns the fetch PC, issues one I-cache block
// request per handoff, builds the IF0->IF1 bus and applies redirects,
// predictor hints, idle halt and misaligned-PC blocking.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_blocks / perf_stall.
// Ports:
//   clk, rst (sync, active high)
//   redirect_valid/redirect_pc   backend redirect, highest priority
//   bpu_taken/bpu_slot/bpu_target predictor hint for the current block
//   halt_req, wake               idle halt / interrupt wake-up
//   ic_req, ic_addr, ic_addr_ok  I-cache request handshake
//   if1_ready, if0_valid, if0_if1_bus  handoff to IF1
//   flush_IF                     flush of IF1 side (redirect cycle)
//   fetch_ade                    misaligned fetch PC pending
//   perf_blocks, perf_stall      (FETCH_PERF_CNT_EN only) event counters
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          BUS_WD   = IF0_TO_IF1_BUS_WD
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              bpu_taken,
  input  logic [1:0]        bpu_slot,
  input  logic [31:0]       bpu_target,
  input  logic              halt_req,
  input  logic              wake,
  output logic              ic_req,
  output logic [31:0]       ic_addr,
  input  logic              ic_addr_ok,
  input  logic              if1_ready,
  output logic              if0_valid,
  output logic [BUS_WD-1:0] if0_if1_bus,
  output logic              flush_IF,
  output logic              fetch_ade
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_blocks,
  output logic [31:0]       perf_stall
`endif
);

  fetch_state_e state_r;
  fetch_state_e next_state_s;
  logic [31:0]  fetch_pc_r;
  logic [31:0]  next_pc_s;
  logic [31:0]  seq_pc_s;
  logic [31:0]  target_pc_s;
  logic         req_s;
  logic         handoff_s;
  logic         use_pred_s;
  logic [3:0]   pc_valid_s;
  logic [3:0]   pc_is_jump_s;

  fetch_mask_gen u_mask_gen (
    .pc_slot    (fetch_pc_r[3:2]),
    .bpu_taken  (bpu_taken),
    .bpu_slot   (bpu_slot),
    .pc_valid   (pc_valid_s),
    .pc_is_jump (pc_is_jump_s),
    .use_pred   (use_pred_s)
  );

  // Request only while running, IF1 has room, and no redirect/halt is being taken.
  assign req_s     = ~rst & (state_r == ST_RUN) & if1_ready & ~redirect_valid & ~halt_req;
  assign handoff_s = req_s & ic_addr_ok;

  assign ic_req      = req_s;
  assign ic_addr     = fetch_pc_r;
  assign if0_valid   = handoff_s;
  assign if0_if1_bus = {pc_valid_s, pc_is_jump_s, fetch_pc_r};
  assign flush_IF    = ~rst & redirect_valid;
  assign fetch_ade   = ~rst & (state_r == ST_BLOCK);

  // Sequential successor is the next 16-byte block; 32-bit wrap is natural.
  assign seq_pc_s    = {fetch_pc_r[31:4] + 28'd1, 4'b0000};
  assign target_pc_s = use_pred_s ? bpu_target : seq_pc_s;

  // Next-state / next-PC selection; redirect overrides everything else.
  always_comb begin
    next_state_s = state_r;
    next_pc_s    = fetch_pc_r;
    if (redirect_valid) begin
      next_pc_s    = redirect_pc;
      next_state_s = pc_misaligned(redirect_pc) ? ST_BLOCK : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (halt_req) begin
            next_state_s = ST_HALT;
          end else if (handoff_s) begin
            next_pc_s    = target_pc_s;
            next_state_s = pc_misaligned(target_pc_s) ? ST_BLOCK : ST_RUN;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_HALT: begin
          if (wake) begin
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_HALT;
          end
        end
        ST_BLOCK: begin
          next_state_s = ST_BLOCK;
        end
        default: begin
          next_state_s = ST_RUN;
        end
      endcase
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      fetch_pc_r <= RESET_PC;
    end else begin
      state_r    <= next_state_s;
      fetch_pc_r <= next_pc_s;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_blocks_r;
  logic [31:0] perf_stall_r;
  logic        stall_s;

  assign stall_s = (state_r == ST_RUN) & ~handoff_s & ~redirect_valid;

  // Handoff and stalled-RUN cycle counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks_r <= 32'd0;
      perf_stall_r  <= 32'd0;
    end else begin
      perf_blocks_r <= perf_blocks_r + {31'd0, handoff_s};
      perf_stall_r  <= perf_stall_r + {31'd0, stall_s};
    end
  end

  assign perf_blocks = perf_blocks_r;
  assign perf_stall  = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed self-checking bench for fetch_pc_ctrl with a
// behavioural fetch model checked every cycle plus literal expectations.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bpu_taken;
  logic [1:0]  bpu_slot;
  logic [31:0] bpu_target;
  logic        halt_req;
  logic        wake;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_addr_ok;
  logic        if1_ready;
  logic        if0_valid;
  logic [39:0] if0_if1_bus;
  logic        flush_IF;
  logic        fetch_ade;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_blocks;
  logic [31:0] perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  fetch_pc_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bpu_taken      (bpu_taken),
    .bpu_slot       (bpu_slot),
    .bpu_target     (bpu_target),
    .halt_req       (halt_req),
    .wake           (wake),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_addr_ok     (ic_addr_ok),
    .if1_ready      (if1_ready),
    .if0_valid      (if0_valid),
    .if0_if1_bus    (if0_if1_bus),
    .flush_IF       (flush_IF),
    .fetch_ade      (fetch_ade)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_blocks    (perf_blocks),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc      = 32'h1c00_0000;
  logic        m_halted  = 1'b0;
  logic        m_blocked = 1'b0;
  logic [31:0] m_blocks  = 32'd0;
  logic [31:0] m_stall   = 32'd0;
  logic [31:0] n_pc      = 32'h1c00_0000;
  logic        n_halted  = 1'b0;
  logic        n_blocked = 1'b0;
  logic [31:0] n_blocks  = 32'd0;
  logic [31:0] n_stall   = 32'd0;

  always @(posedge clk) begin
    m_pc      <= n_pc;
    m_halted  <= n_halted;
    m_blocked <= n_blocked;
    m_blocks  <= n_blocks;
    m_stall   <= n_stall;
  end

  // Compare process: expected outputs from the model, then the model's next state.
  always @(negedge clk) begin
    int  lo, hi, sl;
    bit  pred, e_req, e_hand;
    logic [3:0] e_valid, e_jump;
    logic [31:0] tgt;
    lo     = int'(m_pc[3:2]);
    sl     = int'(bpu_slot);
    pred   = bpu_taken && (sl >= lo);
    hi     = pred ? sl : 3;
    e_valid = 4'(((1 << (hi + 1)) - 1) & ~((1 << lo) - 1));
    e_jump  = pred ? 4'(1 << sl) : 4'b0000;
    e_req  = !rst && !m_halted && !m_blocked && if1_ready && !redirect_valid && !halt_req;
    e_hand = e_req && ic_addr_ok;

    chk("ic_req", {39'd0, ic_req}, {39'd0, e_req});
    chk("if0_valid", {39'd0, if0_valid}, {39'd0, e_hand});
    chk("flush_IF", {39'd0, flush_IF}, {39'd0, (!rst && redirect_valid)});
    chk("fetch_ade", {39'd0, fetch_ade}, {39'd0, (!rst && m_blocked)});
    if (!rst) chk("ic_addr", {8'd0, ic_addr}, {8'd0, m_pc});
    if (e_hand) chk("bus", if0_if1_bus, {e_valid, e_jump, m_pc});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_blocks", {8'd0, perf_blocks}, {8'd0, m_blocks});
    chk("perf_stall", {8'd0, perf_stall}, {8'd0, m_stall});
`endif

    n_pc = m_pc; n_halted = m_halted; n_blocked = m_blocked;
    n_blocks = m_blocks; n_stall = m_stall;
    if (rst) begin
      n_pc = 32'h1c00_0000; n_halted = 1'b0; n_blocked = 1'b0;
      n_blocks = 32'd0; n_stall = 32'd0;
    end else begin
      if (e_hand) n_blocks = m_blocks + 32'd1;
      if (!m_halted && !m_blocked && !e_hand && !redirect_valid) n_stall = m_stall + 32'd1;
      if (redirect_valid) begin
        n_pc = redirect_pc; n_halted = 1'b0; n_blocked = (redirect_pc % 4) != 0;
      end else if (m_halted) begin
        if (wake) n_halted = 1'b0;
      end else if (m_blocked) begin
        n_blocked = 1'b1;
      end else if (halt_req) begin
        n_halted = 1'b1;
      end else if (e_hand) begin
        tgt = pred ? bpu_target : (m_pc - (m_pc % 16)) + 32'd16;
        n_pc = tgt; n_blocked = (tgt % 4) != 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc; tick(); redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    bpu_taken = 1'b0; bpu_slot = 2'd0; bpu_target = 32'd0;
    halt_req = 1'b0; wake = 1'b0; ic_addr_ok = 1'b1; if1_ready = 1'b1;

    // reset
    mid(); chk("rst_ic_req", {39'd0, ic_req}, 40'd0); chk("rst_if0_valid", {39'd0, if0_valid}, 40'd0);
    tick(); tick(); rst = 1'b0;

    // sequential fetch
    mid(); chk("lit_addr0", {8'd0, ic_addr}, 40'h00_1c00_0000);
    chk("lit_mask0", {32'd0, if0_if1_bus[39:32]}, 40'hF0); tick();
    mid(); chk("lit_addr1", {8'd0, ic_addr}, 40'h00_1c00_0010); tick();

    // redirect
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0108;
    mid(); chk("lit_flush", {39'd0, flush_IF}, 40'd1); chk("lit_redir_noreq", {39'd0, ic_req}, 40'd0);
    tick(); redirect_valid = 1'b0;
    mid(); chk("lit_redir_addr", {8'd0, ic_addr}, 40'h00_1c00_0108);
    chk("lit_redir_mask", {32'd0, if0_if1_bus[39:32]}, 40'hC0); tick();
    mid(); chk("lit_after_redir", {8'd0, ic_addr}, 40'h00_1c00_0110); tick();

    // taken prediction at slot 2 from offset 1
    redir(32'h1c00_0004);
    bpu_taken = 1'b1; bpu_slot = 2'd2; bpu_target = 32'h1c00_0400;
    mid(); chk("lit_pred_mask", {32'd0, if0_if1_bus[39:32]}, 40'h64); tick(); bpu_taken = 1'b0;
    mid(); chk("lit_pred_tgt", {8'd0, ic_addr}, 40'h00_1c00_0400); tick();

    // prediction behind the PC is ignored
    redir(32'h1c00_0004);
    bpu_taken = 1'b1; bpu_slot = 2'd0;
    mid(); chk("lit_ign_mask", {32'd0, if0_if1_bus[39:32]}, 40'hE0); tick(); bpu_taken = 1'b0;

    // IF1 backpressure
    if1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("lit_bp_noreq", {39'd0, ic_req}, 40'd0); chk("lit_bp_pc", {8'd0, ic_addr}, 40'h00_1c00_0010); tick();
    end
    if1_ready = 1'b1; ic_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid(); chk("lit_nok_req", {39'd0, ic_req}, 40'd1); chk("lit_nok_valid", {39'd0, if0_valid}, 40'd0); tick();
    end
    ic_addr_ok = 1'b1;

    // halt / wake
    halt_req = 1'b1; mid(); chk("lit_halt_noreq", {39'd0, ic_req}, 40'd0); tick(); halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mid(); chk("lit_halted", {39'd0, ic_req}, 40'd0); tick();
    end
    wake = 1'b1; tick(); wake = 1'b0;
    mid(); chk("lit_resume", {8'd0, ic_addr}, 40'h00_1c00_0010); chk("lit_resume_req", {39'd0, ic_req}, 40'd1); tick();

    // misaligned redirect blocks until an aligned redirect
    redir(32'h1c00_0002);
    for (int i = 0; i < 3; i++) begin
      mid(); chk("lit_ade", {39'd0, fetch_ade}, 40'd1); chk("lit_ade_noreq", {39'd0, ic_req}, 40'd0); tick();
    end
    redir(32'h1c00_0000);
    mid(); chk("lit_unblock", {39'd0, fetch_ade}, 40'd0); chk("lit_unblock_addr", {8'd0, ic_addr}, 40'h00_1c00_0000); tick();

    // 32-bit wrap
    redir(32'hFFFF_FFF0);
    mid(); chk("lit_wrap_pre", {8'd0, ic_addr}, 40'h00_FFFF_FFF0); tick();
    mid(); chk("lit_wrap", {8'd0, ic_addr}, 40'h00_0000_0000); tick();

    // counters: 4 handoffs and 2 stalled RUN cycles after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    ic_addr_ok = 1'b0; tick(); tick(); ic_addr_ok = 1'b1;
    tick(); tick();
    if1_ready = 1'b0;
    mid();
    chk("lit_perf_addr", {8'd0, ic_addr}, 40'h00_1c00_0040);
`ifdef FETCH_PERF_CNT_EN
    chk("lit_perf_blocks", {8'd0, perf_blocks}, 40'd4);
    chk("lit_perf_stall", {8'd0, perf_stall}, 40'd2);
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
